// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: default widths and the
// single-bit full-adder cell the segment adders are built from.
// Contents: DEF_DATA_WID, DEF_SEG_WID, fa().
package pipelined_adder_pkg;

  localparam int DEF_DATA_WID = 64;
  localparam int DEF_SEG_WID  = 16;

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/pipelined_adder_seg_adder.sv
// seg_adder: purely combinational SEG_WID-bit ripple-carry adder built
// from the full-adder cell in the package.
// Ports: InputA/InputB operands, CarryInput, Sum, CarryOutput.
module seg_adder
  import pipelined_adder_pkg::*;
#(
  parameter int SEG_WID = DEF_SEG_WID
) (
  input  logic [SEG_WID-1:0] InputA,
  input  logic [SEG_WID-1:0] InputB,
  input  logic               CarryInput,
  output logic [SEG_WID-1:0] Sum,
  output logic               CarryOutput
);

  logic [SEG_WID:0] carry;

  always_comb begin
    carry    = '0;
    Sum      = '0;
    carry[0] = CarryInput;
    for (int i = 0; i < SEG_WID; i++) begin
      {carry[i+1], Sum[i]} = fa(InputA[i], InputB[i], carry[i]);
    end
  end

  assign CarryOutput = carry[SEG_WID];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: DATA_WID-bit add/subtract split into NUM_STG ripple
// segments with one register stage per segment, valid/ready on both sides.
// Ports: Clock, Reset, InValid/InReady/InputA/InputB/CarryInput/Subtract in,
// OutValid/OutReady/Sum/CarryOutput/Overflow/Zero out. Latency NUM_STG.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int DATA_WID = DEF_DATA_WID,
  parameter int SEG_WID  = DEF_SEG_WID
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                InValid,
  output logic                InReady,
  input  logic [DATA_WID-1:0] InputA,
  input  logic [DATA_WID-1:0] InputB,
  input  logic                CarryInput,
  input  logic                Subtract,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [DATA_WID-1:0] Sum,
  output logic                CarryOutput,
  output logic                Overflow,
  output logic                Zero
);

  localparam int NUM_STG = DATA_WID / SEG_WID;
  localparam int LST     = NUM_STG - 1;

  if (SEG_WID < 1 || SEG_WID > DATA_WID || (DATA_WID % SEG_WID) != 0) begin : g_bad_cfg
    $error("pipelined_adder: DATA_WID must be a positive multiple of SEG_WID");
  end

  typedef logic [DATA_WID-1:0] word_t;

  // Per-stage state. a/b carry the full operands forward so each later
  // stage can pick its own slice (input skew); res accumulates finished
  // slices (output deskew). The last stage's a/b MSBs feed Overflow.
  logic [NUM_STG-1:0] vld_q, vld_d;
  logic [NUM_STG-1:0] cry_q, cry_d;
  word_t              a_q   [NUM_STG];
  word_t              a_d   [NUM_STG];
  word_t              b_q   [NUM_STG];
  word_t              b_d   [NUM_STG];
  word_t              res_q [NUM_STG];
  word_t              res_d [NUM_STG];

  // Inputs seen by each stage: stage 0 from the ports, stage k from k-1.
  logic [NUM_STG-1:0]              v_in;
  logic [NUM_STG-1:0]              c_in;
  word_t                           a_in [NUM_STG];
  word_t                           b_in [NUM_STG];
  word_t                           r_in [NUM_STG];
  logic [NUM_STG-1:0][SEG_WID-1:0] seg_s;
  logic [NUM_STG-1:0]              seg_co;

  logic  adv;
  word_t b_cond;
  logic  c0;

  // Subtract is A + ~B + ~borrow, so the carry-out reads as "no borrow".
  assign b_cond  = Subtract ? ~InputB : InputB;
  assign c0      = Subtract ^ CarryInput;
  assign adv     = ~vld_q[LST] | OutReady;
  assign InReady = adv & ~Reset;

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    if (k == 0) begin : g_first
      assign v_in[k] = InValid & InReady;
      assign c_in[k] = c0;
      assign a_in[k] = InputA;
      assign b_in[k] = b_cond;
      assign r_in[k] = '0;
    end else begin : g_next
      assign v_in[k] = vld_q[k-1];
      assign c_in[k] = cry_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign r_in[k] = res_q[k-1];
    end

    seg_adder #(.SEG_WID(SEG_WID)) u_seg (
      .InputA      (a_in[k][k*SEG_WID +: SEG_WID]),
      .InputB      (b_in[k][k*SEG_WID +: SEG_WID]),
      .CarryInput  (c_in[k]),
      .Sum         (seg_s[k]),
      .CarryOutput (seg_co[k])
    );
  end

  // The whole pipe shifts together or holds together; bubbles are not
  // squeezed out, which keeps the stall logic to a single enable.
  always_comb begin
    vld_d = vld_q;
    cry_d = cry_q;
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    if (adv) begin
      vld_d = v_in;
      cry_d = seg_co;
      for (int k = 0; k < NUM_STG; k++) begin
        a_d[k]                         = a_in[k];
        b_d[k]                         = b_in[k];
        res_d[k]                       = r_in[k];
        res_d[k][k*SEG_WID +: SEG_WID] = seg_s[k];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vld_q <= '0;
      cry_q <= '0;
      for (int k = 0; k < NUM_STG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cry_q <= cry_d;
      for (int k = 0; k < NUM_STG; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  assign OutValid    = vld_q[LST];
  assign Sum         = res_q[LST];
  assign CarryOutput = cry_q[LST];
  assign Overflow    = (a_q[LST][DATA_WID-1] == b_q[LST][DATA_WID-1]) &
                       (res_q[LST][DATA_WID-1] != a_q[LST][DATA_WID-1]);
  // Qualified by valid so a cleared (all-zero) pipe does not report Zero.
  assign Zero        = vld_q[LST] & ~|res_q[LST];

endmodule
